dec_stage: RTL and testbench

- Parametrised N-wide decode stage for the corev2 superscalar frontend.
- Sits between fetch and rename. Instantiates one decoder per lane and registers the decoded micro-ops into a two-entry skid buffer.
- Adds what the fixed two-line decode lacks:
  - per-lane valid bits;
  - a valid/ready handshake on both sides, with a registered ready;
  - flush;
  - illegal-instruction group truncation, with a blocking state held until flush.

---
 rtl/dec_stage_pkg.sv | 48 ++++
 rtl/dec_decoder.sv | 134 +++++++++++++
 rtl/dec_skid_buf.sv | 76 +++++++
 rtl/dec_stage.sv | 103 ++++++++++
 tb/tb_dec_stage.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dec_stage_pkg.sv
`default_nettype none
// ============================================================
// Package : dec_stage_pkg
// Desc    : Shared types for the corev2 decode stage.
// Rev     : 1.0 - initial release
// ============================================================
package dec_stage_pkg;

    localparam int XLEN           = 32;
    localparam int FRONTEND_WIDTH = 2;

    // One-hot instruction class carried in dec_uop_t.instr_type
    localparam logic [12:0] IT_LUI    = 13'h0001;
    localparam logic [12:0] IT_AUIPC  = 13'h0002;
    localparam logic [12:0] IT_JAL    = 13'h0004;
    localparam logic [12:0] IT_JALR   = 13'h0008;
    localparam logic [12:0] IT_BRANCH = 13'h0010;
    localparam logic [12:0] IT_LOAD   = 13'h0020;
    localparam logic [12:0] IT_STORE  = 13'h0040;
    localparam logic [12:0] IT_OPIMM  = 13'h0080;
    localparam logic [12:0] IT_OP     = 13'h0100;

    typedef struct packed {
        logic            illegal;
        logic            rd_v;
        logic [4:0]      rd;
        logic            rs1_v;
        logic [4:0]      rs1;
        logic            rs2_v;
        logic [4:0]      rs2;
        logic            rs2_is_immediat;
        logic            is_store;
        logic            is_load;
        logic            is_branch;
        logic [31:0]     immediat;
        logic [2:0]      access_size;
        logic [12:0]     instr_type;
        logic            unsign_extension;
        logic [XLEN-1:0] pc;
    } dec_uop_t;

    typedef enum logic [0:0] {
        DEC_RUN     = 1'b0,
        DEC_BLOCKED = 1'b1
    } dec_state_t;

endpackage
`default_nettype wire

// File: rtl/dec_decoder.sv
`default_nettype none
// ============================================================
// Module : dec_decoder
// Desc   : Combinational RV32I decoder producing one micro-op.
// Rev    : 1.0 - initial release
// ============================================================
module dec_decoder
    import dec_stage_pkg::*;
(
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output dec_uop_t        uop_o
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic        w_unsigned;
    logic        w_legal;
    logic        w_use_rd;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    assign w_opcode   = instr_i[6:0];
    assign w_f3       = instr_i[14:12];
    assign w_f7       = instr_i[31:25];
    assign w_unsigned = ((w_opcode == 7'b0000011) && w_f3[2]) ||
                        (((w_opcode == 7'b0010011) || (w_opcode == 7'b0110011)) && (w_f3 == 3'b011));
    assign w_imm_i    = w_unsigned ? {20'd0, instr_i[31:20]} : {{20{instr_i[31]}}, instr_i[31:20]};
    assign w_imm_s    = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign w_imm_b    = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign w_imm_u    = {instr_i[31:12], 12'd0};
    assign w_imm_j    = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        uop_o     = '0;
        w_legal   = 1'b1;
        w_use_rd  = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (w_opcode)
            7'b0110111, 7'b0010111: begin
                w_use_rd              = 1'b1;
                uop_o.rs2_is_immediat = 1'b1;
                uop_o.immediat        = w_imm_u;
                uop_o.instr_type      = w_opcode[5] ? IT_LUI : IT_AUIPC;
            end
            7'b1101111: begin
                w_use_rd         = 1'b1;
                uop_o.is_branch  = 1'b1;
                uop_o.immediat   = w_imm_j;
                uop_o.instr_type = IT_JAL;
            end
            7'b1100111: begin
                w_legal               = (w_f3 == 3'b000);
                w_use_rd              = 1'b1;
                w_use_rs1             = 1'b1;
                uop_o.is_branch       = 1'b1;
                uop_o.rs2_is_immediat = 1'b1;
                uop_o.immediat        = w_imm_i;
                uop_o.instr_type      = IT_JALR;
            end
            7'b1100011: begin
                w_legal          = (w_f3[2:1] != 2'b01);
                w_use_rs1        = 1'b1;
                w_use_rs2        = 1'b1;
                uop_o.is_branch  = 1'b1;
                uop_o.immediat   = w_imm_b;
                uop_o.instr_type = IT_BRANCH;
            end
            7'b0000011: begin
                w_legal               = (w_f3[1:0] != 2'b11) && !(w_f3[2] && w_f3[1]);
                w_use_rd              = 1'b1;
                w_use_rs1             = 1'b1;
                uop_o.is_load         = 1'b1;
                uop_o.rs2_is_immediat = 1'b1;
                uop_o.immediat        = w_imm_i;
                uop_o.access_size     = w_f3;
                uop_o.instr_type      = IT_LOAD;
            end
            7'b0100011: begin
                w_legal           = !w_f3[2] && (w_f3[1:0] != 2'b11);
                w_use_rs1         = 1'b1;
                w_use_rs2         = 1'b1;
                uop_o.is_store    = 1'b1;
                uop_o.immediat    = w_imm_s;
                uop_o.access_size = w_f3;
                uop_o.instr_type  = IT_STORE;
            end
            7'b0010011: begin
                // Shift-immediates reuse imm[11:5] as funct7
                if (w_f3 == 3'b001) begin
                    w_legal = (w_f7 == 7'd0);
                end else if (w_f3 == 3'b101) begin
                    w_legal = (w_f7 == 7'd0) || (w_f7 == 7'b0100000);
                end
                w_use_rd              = 1'b1;
                w_use_rs1             = 1'b1;
                uop_o.rs2_is_immediat = 1'b1;
                uop_o.immediat        = w_imm_i;
                uop_o.instr_type      = IT_OPIMM;
            end
            7'b0110011: begin
                w_legal          = (w_f7 == 7'd0) ||
                                   ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
                w_use_rd         = 1'b1;
                w_use_rs1        = 1'b1;
                w_use_rs2        = 1'b1;
                uop_o.instr_type = IT_OP;
            end
            default: w_legal = 1'b0;
        endcase

        uop_o.rd_v             = w_use_rd;
        uop_o.rd               = w_use_rd  ? instr_i[11:7]  : 5'd0;
        uop_o.rs1_v            = w_use_rs1;
        uop_o.rs1              = w_use_rs1 ? instr_i[19:15] : 5'd0;
        uop_o.rs2_v            = w_use_rs2;
        uop_o.rs2              = w_use_rs2 ? instr_i[24:20] : 5'd0;
        uop_o.unsign_extension = w_unsigned;
        if (!w_legal) begin
            uop_o         = '0;
            uop_o.illegal = 1'b1;
        end
        uop_o.pc = pc_i;
    end

endmodule
`default_nettype wire

// File: rtl/dec_skid_buf.sv
`default_nettype none
// ============================================================
// Module : dec_skid_buf
// Desc   : Two-entry (main + skid) group buffer with flush.
// Rev    : 1.0 - initial release
// ============================================================
module dec_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             skid_valid_next_o
);

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             w_issue;

    assign w_issue = main_valid_q && out_ready_i;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (w_issue) begin
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                skid_valid_d = in_valid_i;
                if (in_valid_i) skid_data_d = in_data_i;
            end else begin
                main_valid_d = in_valid_i;
                if (in_valid_i) main_data_d = in_data_i;
            end
        end else if (in_valid_i) begin
            if (!main_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data_i;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign out_valid_o       = main_valid_q;
    assign out_data_o        = main_data_q;
    assign skid_valid_next_o = skid_valid_d;

endmodule
`default_nettype wire

// File: rtl/dec_stage.sv
`default_nettype none
// ============================================================
// Module : dec_stage
// Desc   : N-wide decode stage between fetch and rename.
// Rev    : 1.0 - initial release
// ============================================================
module dec_stage #(
    parameter int FRONTEND_WIDTH = dec_stage_pkg::FRONTEND_WIDTH,
    parameter int XLEN           = dec_stage_pkg::XLEN
) (
    input  logic                                        clk,
    input  logic                                        resetn,
    input  logic                                        flush_i,
    input  logic [FRONTEND_WIDTH-1:0]                   fet_valid_i,
    input  logic [FRONTEND_WIDTH*XLEN-1:0]              fet_instr_i,
    input  logic [FRONTEND_WIDTH*XLEN-1:0]              fet_pc_i,
    output logic                                        dec_ready_o,
    output logic [FRONTEND_WIDTH-1:0]                   ren_valid_o,
    output dec_stage_pkg::dec_uop_t [FRONTEND_WIDTH-1:0] ren_uop_o,
    input  logic                                        ren_ready_i
);

    localparam int UOP_W = $bits(dec_stage_pkg::dec_uop_t);
    localparam int GRP_W = FRONTEND_WIDTH * (UOP_W + 1);

    dec_stage_pkg::dec_uop_t [FRONTEND_WIDTH-1:0] w_uop;
    dec_stage_pkg::dec_state_t                    state_q, state_d;
    logic [FRONTEND_WIDTH-1:0] w_grp_valid;
    logic [FRONTEND_WIDTH-1:0] w_fet_valid_inc;
    logic [FRONTEND_WIDTH-1:0] w_main_lane_valid;
    logic [GRP_W-1:0]          w_main_data;
    logic                      w_any_illegal;
    logic                      w_accept;
    logic                      w_main_valid;
    logic                      w_skid_valid_next;
    logic                      dec_ready_q, dec_ready_d;

    for (genvar gi = 0; gi < FRONTEND_WIDTH; gi++) begin : g_lane
        dec_decoder u_dec (
            .instr_i (fet_instr_i[gi*XLEN +: XLEN]),
            .pc_i    (fet_pc_i[gi*XLEN +: XLEN]),
            .uop_o   (w_uop[gi])
        );
    end

    // Keep lanes up to and including the oldest illegal one
    always_comb begin
        w_grp_valid   = '0;
        w_any_illegal = 1'b0;
        for (int i = 0; i < FRONTEND_WIDTH; i++) begin
            w_grp_valid[i] = fet_valid_i[i] && !w_any_illegal;
            w_any_illegal  = w_any_illegal || (fet_valid_i[i] && w_uop[i].illegal);
        end
    end

    assign w_accept = (|fet_valid_i) && dec_ready_q && !flush_i;

    dec_skid_buf #(
        .WIDTH (GRP_W)
    ) u_skid (
        .clk               (clk),
        .resetn            (resetn),
        .flush_i           (flush_i),
        .in_valid_i        (w_accept),
        .in_data_i         ({w_grp_valid, w_uop}),
        .out_ready_i       (ren_ready_i),
        .out_valid_o       (w_main_valid),
        .out_data_o        (w_main_data),
        .skid_valid_next_o (w_skid_valid_next)
    );

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = dec_stage_pkg::DEC_RUN;
        end else if (w_accept && w_any_illegal) begin
            state_d = dec_stage_pkg::DEC_BLOCKED;
        end
        dec_ready_d = !w_skid_valid_next && (state_d == dec_stage_pkg::DEC_RUN);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= dec_stage_pkg::DEC_RUN;
            dec_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            dec_ready_q <= dec_ready_d;
        end
    end

    assign w_main_lane_valid = w_main_data[GRP_W-1 -: FRONTEND_WIDTH];
    assign ren_valid_o       = w_main_lane_valid & {FRONTEND_WIDTH{w_main_valid}};
    assign ren_uop_o         = w_main_data[FRONTEND_WIDTH*UOP_W-1:0];
    assign dec_ready_o       = dec_ready_q;

    assign w_fet_valid_inc = fet_valid_i + 1'b1;

    a_valid_prefix : assert property (@(posedge clk) disable iff (!resetn)
        (fet_valid_i & w_fet_valid_inc) == '0);

endmodule
`default_nettype wire

// File: tb/tb_dec_stage.sv
`default_nettype none
// ============================================================
// Module : tb_dec_stage
// Desc   : Scoreboard bench for dec_stage.
// Rev    : 1.0 - initial release
// ============================================================
module tb_dec_stage;
    import dec_stage_pkg::*;

    localparam int FW = 2;
    localparam int XL = 32;
    localparam logic [31:0] I_ADDI = 32'h00500093; // addi x1,x0,5
    localparam logic [31:0] I_ADD  = 32'h00108133; // add  x2,x1,x1
    localparam logic [31:0] I_LW   = 32'h00812183; // lw   x3,8(x2)
    localparam logic [31:0] I_SW   = 32'hFE532E23; // sw   x5,-4(x6)
    localparam logic [31:0] I_ZERO = 32'h00000000;
    localparam logic [31:0] I_ONES = 32'hFFFFFFFF;

    typedef struct packed {
        logic [FW-1:0]      v;
        dec_uop_t [FW-1:0]  u;
    } grp_t;

    logic                 clk = 1'b0;
    logic                 resetn = 1'b0;
    logic                 flush_i = 1'b0;
    logic                 ren_ready_i = 1'b1;
    logic [FW-1:0]        fet_valid_i = '0;
    logic [FW*XL-1:0]     fet_instr_i = '0;
    logic [FW*XL-1:0]     fet_pc_i = '0;
    logic                 dec_ready_o;
    logic [FW-1:0]        ren_valid_o;
    dec_uop_t [FW-1:0]    ren_uop_o;

    int   checks = 0;
    int   errors = 0;
    grp_t sb_q[$];
    grp_t sb_e;

    dec_stage #(.FRONTEND_WIDTH(FW), .XLEN(XL)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush_i     (flush_i),
        .fet_valid_i (fet_valid_i),
        .fet_instr_i (fet_instr_i),
        .fet_pc_i    (fet_pc_i),
        .dec_ready_o (dec_ready_o),
        .ren_valid_o (ren_valid_o),
        .ren_uop_o   (ren_uop_o),
        .ren_ready_i (ren_ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic dec_uop_t exp_uop(input logic [31:0] ins, input logic [31:0] pc);
        dec_uop_t u;
        u    = '0;
        u.pc = pc;
        case (ins)
            I_ADDI: begin
                u.rd_v = 1'b1; u.rd = 5'd1; u.rs1_v = 1'b1; u.rs2_is_immediat = 1'b1;
                u.immediat = 32'd5; u.instr_type = IT_OPIMM;
            end
            I_ADD: begin
                u.rd_v = 1'b1; u.rd = 5'd2; u.rs1_v = 1'b1; u.rs1 = 5'd1;
                u.rs2_v = 1'b1; u.rs2 = 5'd1; u.instr_type = IT_OP;
            end
            I_LW: begin
                u.rd_v = 1'b1; u.rd = 5'd3; u.rs1_v = 1'b1; u.rs1 = 5'd2; u.rs2_is_immediat = 1'b1;
                u.is_load = 1'b1; u.immediat = 32'd8; u.access_size = 3'b010; u.instr_type = IT_LOAD;
            end
            I_SW: begin
                u.rs1_v = 1'b1; u.rs1 = 5'd6; u.rs2_v = 1'b1; u.rs2 = 5'd5; u.is_store = 1'b1;
                u.immediat = 32'hFFFFFFFC; u.access_size = 3'b010; u.instr_type = IT_STORE;
            end
            default: u.illegal = 1'b1;
        endcase
        return u;
    endfunction

    function automatic grp_t model_grp();
        grp_t g;
        logic stop;
        g    = '0;
        stop = 1'b0;
        for (int i = 0; i < FW; i++) begin
            g.u[i] = exp_uop(fet_instr_i[i*XL +: XL], fet_pc_i[i*XL +: XL]);
            g.v[i] = fet_valid_i[i] && !stop;
            stop   = stop || (fet_valid_i[i] && g.u[i].illegal);
        end
        return g;
    endfunction

    // Sample just before each rising edge
    always @(negedge clk) begin
        #4;
        if (!resetn) begin
            sb_q.delete();
        end else begin
            if ((ren_valid_o != '0) && ren_ready_i) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected", 256'(ren_valid_o), 256'(0));
                end else begin
                    sb_e = sb_q.pop_front();
                    chk("sb_valid", 256'(ren_valid_o), 256'(sb_e.v));
                    for (int i = 0; i < FW; i++)
                        if (sb_e.v[i]) chk("sb_uop", 256'(ren_uop_o[i]), 256'(sb_e.u[i]));
                end
            end
            if (flush_i) sb_q.delete();
            else if ((|fet_valid_i) && dec_ready_o) sb_q.push_back(model_grp());
        end
    end

    task automatic send(input logic [31:0] ins0, input logic [31:0] ins1,
                        input logic [31:0] pc0, input logic [FW-1:0] v);
        int n;
        n = 0;
        fet_valid_i = v;
        fet_instr_i = {ins1, ins0};
        fet_pc_i    = {pc0 + 32'd4, pc0};
        while (!dec_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("send_timeout", 256'(dec_ready_o), 256'(1));
        @(negedge clk);
        fet_valid_i = '0;
    endtask

    initial begin
        time t0, t1;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_ready", 256'(dec_ready_o), 256'(1));
        chk("rst_valid", 256'(ren_valid_o), 256'(0));
        chk("rst_uop",   256'(ren_uop_o),   256'(0));

        // Steady stream, one group per cycle
        t0 = $time;
        for (int k = 0; k < 4; k++) send(I_ADDI, I_ADD, 32'h1000 + 32'(k * 8), 2'b11);
        t1 = $time;
        chk("stream_rate", 256'(t1 - t0), 256'(40));
        chk("stream_lat", 256'(ren_valid_o), 256'(2'b11));
        chk("stream_rd", 256'(ren_uop_o[0].rd), 256'(1));
        @(negedge clk);

        // Backpressure: A held, B skid, C waits
        fork
            begin
                send(I_ADDI, I_ADD, 32'h2000, 2'b11);
                send(I_ADD, I_ADDI, 32'h2100, 2'b11);
                send(I_LW, I_ADD, 32'h2200, 2'b11);
            end
            begin
                ren_ready_i = 1'b0;
                repeat (2) @(negedge clk);
                chk("bp_ready", 256'(dec_ready_o), 256'(0));
                chk("bp_hold", 256'(ren_valid_o), 256'(2'b11));
                chk("bp_pcA", 256'(ren_uop_o[0].pc), 256'(32'h2000));
                @(negedge clk);
                ren_ready_i = 1'b1;
            end
        join
        repeat (2) @(negedge clk);

        // Illegal in lane 1: both lanes kept, then blocked
        send(I_LW, I_ZERO, 32'h3000, 2'b11);
        chk("ill1_valid", 256'(ren_valid_o), 256'(2'b11));
        chk("ill1_flag", 256'(ren_uop_o[1].illegal), 256'(1));
        chk("ill1_block", 256'(dec_ready_o), 256'(0));
        repeat (3) @(negedge clk);
        chk("ill1_hold", 256'(dec_ready_o), 256'(0));
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("ill1_unblock", 256'(dec_ready_o), 256'(1));

        // Illegal in lane 0: lane 1 truncated
        send(I_ZERO, I_ADD, 32'h3100, 2'b11);
        chk("ill0_valid", 256'(ren_valid_o), 256'(2'b01));
        chk("ill0_block", 256'(dec_ready_o), 256'(0));
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("ill0_unblock", 256'(dec_ready_o), 256'(1));

        // Flush with both entries full and a group on the input
        ren_ready_i = 1'b0;
        send(I_ADDI, I_ADD, 32'h4000, 2'b11);
        send(I_ADD, I_ADDI, 32'h4100, 2'b11);
        chk("fl_full", 256'(dec_ready_o), 256'(0));
        fet_valid_i = 2'b11;
        fet_instr_i = {I_ADD, I_LW};
        fet_pc_i    = {32'h4204, 32'h4200};
        flush_i     = 1'b1;
        @(negedge clk);
        flush_i     = 1'b0;
        fet_valid_i = '0;
        chk("fl_valid", 256'(ren_valid_o), 256'(0));
        chk("fl_ready", 256'(dec_ready_o), 256'(1));
        ren_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("fl_gone", 256'(ren_valid_o), 256'(0));

        // Partial group; invalid illegal lane must not block
        send(I_SW, I_ONES, 32'h5000, 2'b01);
        chk("part_valid", 256'(ren_valid_o), 256'(2'b01));
        chk("part_store", 256'(ren_uop_o[0].is_store), 256'(1));
        chk("part_size", 256'(ren_uop_o[0].access_size), 256'(3'b010));
        chk("part_imm", 256'(ren_uop_o[0].immediat), 256'(32'hFFFFFFFC));
        chk("part_ready", 256'(dec_ready_o), 256'(1));
        @(negedge clk);

        // Asynchronous reset with both entries full
        ren_ready_i = 1'b0;
        send(I_ADDI, I_ADD, 32'h6000, 2'b11);
        send(I_LW, I_ADD, 32'h6100, 2'b11);
        #2 resetn = 1'b0;
        #1 chk("rst_async", 256'(ren_valid_o), 256'(0));
        repeat (2) @(negedge clk);
        resetn      = 1'b1;
        ren_ready_i = 1'b1;
        @(negedge clk);
        chk("rst2_ready", 256'(dec_ready_o), 256'(1));
        chk("rst2_valid", 256'(ren_valid_o), 256'(0));
        chk("rst2_uop",   256'(ren_uop_o),   256'(0));
        repeat (2) @(negedge clk);
        chk("rst2_quiet", 256'(ren_valid_o), 256'(0));
        chk("sb_empty", 256'(sb_q.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
